// File: rtl/ptw_arbiter_pkg.sv
// Shared types for the ITLB/DTLB page-table-walker arbiter.
package ptw_arbiter_pkg;

  // Walk sequencing: grant -> request pulse -> wait for ptw -> respond.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Which TLB owns the walker (also used for the round-robin history).
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Watchdog counter width: enough bits to hold TIMEOUT.
  function automatic int wdog_bits(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/ptw_arbiter.sv
// Round-robin arbiter sharing one page-table walker between ITLB and DTLB,
// with per-TLB flush and a watchdog that fault-completes hung walks.
module ptw_arbiter
  import ptw_arbiter_pkg::*;
#(
  parameter int VA_WIDTH  = 32,
  parameter int PPN_WIDTH = 20,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [VA_WIDTH-1:0]  i_va,
  input  logic                 i_flush,
  output logic                 i_valid,
  output logic [PPN_WIDTH-1:0] i_pa,
  output logic                 i_fault,
  input  logic                 d_req,
  input  logic [VA_WIDTH-1:0]  d_va,
  input  logic                 d_flush,
  output logic                 d_valid,
  output logic [PPN_WIDTH-1:0] d_pa,
  output logic                 d_fault,
  output logic                 ptw_req,
  output logic [VA_WIDTH-1:0]  ptw_va,
  input  logic                 ptw_valid,
  input  logic [PPN_WIDTH-1:0] ptw_pa,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int WDOG_BITS = wdog_bits(TIMEOUT);
  localparam logic [WDOG_BITS-1:0] WDOG_LAST = WDOG_BITS'(TIMEOUT - 1);

  state_t                state;
  owner_t                owner;
  owner_t                last_grant;
  logic                  own_valid;
  logic                  drop;
  logic                  i_pend;
  logic                  d_pend;
  logic [VA_WIDTH-1:0]   i_va_q;
  logic [VA_WIDTH-1:0]   d_va_q;
  logic [WDOG_BITS-1:0]  count;

  logic i_owned;
  logic d_owned;
  logic i_take;
  logic d_take;
  logic i_cand;
  logic d_cand;
  logic grant_d;
  logic owner_flush;
  logic walk_done;
  logic deliver;

  // Capture qualification, IDLE grant choice and flush-of-owner detection.
  always_comb begin
    i_owned     = own_valid && (owner == OWN_I);
    d_owned     = own_valid && (owner == OWN_D);
    i_take      = i_req && !i_flush && !i_pend && !i_owned;
    d_take      = d_req && !d_flush && !d_pend && !d_owned;
    // A request arriving in IDLE is eligible in the same cycle.
    i_cand      = (i_pend || i_req) && !i_flush;
    d_cand      = (d_pend || d_req) && !d_flush;
    grant_d     = d_cand && (!i_cand || (last_grant == OWN_I));
    owner_flush = (i_owned && i_flush) || (d_owned && d_flush);
    walk_done   = ptw_valid || (count == WDOG_LAST);
    // A flush landing on the completing cycle suppresses the response too.
    deliver     = !(drop || owner_flush);
  end

  assign busy = (state != ST_IDLE);

  // Pending capture, arbitration FSM and registered responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner       <= OWN_I;
      last_grant  <= OWN_D;
      own_valid   <= 1'b0;
      drop        <= 1'b0;
      i_pend      <= 1'b0;
      d_pend      <= 1'b0;
      i_va_q      <= '0;
      d_va_q      <= '0;
      count       <= '0;
      ptw_req     <= 1'b0;
      ptw_va      <= '0;
      i_valid     <= 1'b0;
      i_pa        <= '0;
      i_fault     <= 1'b0;
      d_valid     <= 1'b0;
      d_pa        <= '0;
      d_fault     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      ptw_req <= 1'b0;
      i_valid <= 1'b0;
      i_fault <= 1'b0;
      d_valid <= 1'b0;
      d_fault <= 1'b0;

      if (i_flush) begin
        i_pend <= 1'b0;
      end else if (i_take) begin
        i_pend <= 1'b1;
        i_va_q <= i_va;
      end

      if (d_flush) begin
        d_pend <= 1'b0;
      end else if (d_take) begin
        d_pend <= 1'b1;
        d_va_q <= d_va;
      end

      if (owner_flush) begin
        drop <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          // The granted side's pend clear below overrides any same-cycle capture.
          if (i_cand || d_cand) begin
            own_valid <= 1'b1;
            ptw_req   <= 1'b1;
            state     <= ST_ISSUE;
            if (grant_d) begin
              owner  <= OWN_D;
              d_pend <= 1'b0;
              ptw_va <= d_pend ? d_va_q : d_va;
            end else begin
              owner  <= OWN_I;
              i_pend <= 1'b0;
              ptw_va <= i_pend ? i_va_q : i_va;
            end
          end
        end

        ST_ISSUE: begin
          count <= '0;
          state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (walk_done) begin
            state <= ST_RESP;
            if (!ptw_valid) begin
              timeout_err <= 1'b1;
            end
            if (deliver) begin
              if (owner == OWN_I) begin
                i_valid <= 1'b1;
                i_fault <= !ptw_valid;
                i_pa    <= ptw_valid ? ptw_pa : '0;
              end else begin
                d_valid <= 1'b1;
                d_fault <= !ptw_valid;
                d_pa    <= ptw_valid ? ptw_pa : '0;
              end
            end
          end else begin
            count <= count + 1'b1;
          end
        end

        ST_RESP: begin
          last_grant <= owner;
          own_valid  <= 1'b0;
          drop       <= 1'b0;
          state      <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ptw_arbiter.sv
// Directed bench for ptw_arbiter with a fixed-latency ptw stub (PA = VA[19:0]+4).
module tb_ptw_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, i_flush = 1'b0, d_req = 1'b0, d_flush = 1'b0;
  logic [31:0] i_va = '0, d_va = '0;
  logic        i_valid, i_fault, d_valid, d_fault;
  logic [19:0] i_pa, d_pa;
  logic        ptw_req, busy, timeout_err;
  logic [31:0] ptw_va;
  logic        ptw_valid;
  logic [19:0] ptw_pa;

  logic        stub_valid = 1'b0, force_valid = 1'b0, stub_en = 1'b1;
  logic [19:0] stub_pa = '0, force_pa = '0;
  logic [31:0] stub_va = '0;
  int          stub_cnt = 0;

  assign ptw_valid = stub_valid | force_valid;
  assign ptw_pa    = force_valid ? force_pa : stub_pa;

  always #5 clk = ~clk;

  ptw_arbiter #(.VA_WIDTH(32), .PPN_WIDTH(20), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_va(i_va), .i_flush(i_flush),
    .i_valid(i_valid), .i_pa(i_pa), .i_fault(i_fault),
    .d_req(d_req), .d_va(d_va), .d_flush(d_flush),
    .d_valid(d_valid), .d_pa(d_pa), .d_fault(d_fault),
    .ptw_req(ptw_req), .ptw_va(ptw_va),
    .ptw_valid(ptw_valid), .ptw_pa(ptw_pa),
    .busy(busy), .timeout_err(timeout_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor and ptw stub, evaluated mid-cycle.
  int          n_req = 0, n_i = 0, n_d = 0;
  int          last_req_cyc = 0, i_cyc = 0, d_cyc = 0, pv_cyc = 0, last_busy_cyc = 0;
  logic [31:0] last_req_va = '0;
  logic [19:0] got_i_pa = '0, got_d_pa = '0;
  logic        got_i_fault = 1'b0, got_d_fault = 1'b0;

  always @(negedge clk) begin
    if (i_valid) begin n_i++; i_cyc = cyc; got_i_pa = i_pa; got_i_fault = i_fault; end
    if (d_valid) begin n_d++; d_cyc = cyc; got_d_pa = d_pa; got_d_fault = d_fault; end
    if (busy) last_busy_cyc = cyc;
    stub_valid = 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        stub_valid = 1'b1;
        stub_pa    = stub_va[19:0] + 20'h4;
        pv_cyc     = cyc;
      end
    end
    if (ptw_req) begin
      n_req++;
      last_req_cyc = cyc;
      last_req_va  = ptw_va;
      if (stub_en) begin
        stub_cnt = 8;
        stub_va  = ptw_va;
      end
    end
  end

  int n_tests = 0, n_fail = 0;
  int req_cyc = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic ir, input logic [31:0] iva, input logic ifl,
                       input logic dr, input logic [31:0] dva, input logic dfl);
    @(negedge clk);
    i_req = ir; i_va = iva; i_flush = ifl;
    d_req = dr; d_va = dva; d_flush = dfl;
    req_cyc = cyc;
    @(negedge clk);
    i_req = 1'b0; d_req = 1'b0; i_flush = 1'b0; d_flush = 1'b0;
  endtask

  typedef struct {
    logic        fi;
    logic        fd;
    logic [31:0] iva;
    logic [31:0] dva;
    logic [19:0] ipa;
    logic [19:0] dpa;
    logic        d_first;
  } vec_t;

  vec_t vt[5];
  int   s_req, s_i, s_d;
  logic [19:0] prev_ipa, prev_dpa;

  initial begin
    vt[0] = '{1'b1, 1'b1, 32'h0000_1000, 32'h0002_0000, 20'h01004, 20'h20004, 1'b0};
    vt[1] = '{1'b1, 1'b0, 32'h0000_5008, 32'h0000_0000, 20'h0500C, 20'h00000, 1'b0};
    vt[2] = '{1'b1, 1'b1, 32'h1234_5678, 32'hFFFF_FFF0, 20'h4567C, 20'hFFFF4, 1'b1};
    vt[3] = '{1'b1, 1'b1, 32'h000F_FFFC, 32'h0000_0ABC, 20'h00000, 20'h00AC0, 1'b1};
    vt[4] = '{1'b0, 1'b1, 32'h0000_0000, 32'h8000_0000, 20'h00000, 20'h00004, 1'b0};
    prev_ipa = '0;
    prev_dpa = '0;

    // Reset state
    cycles(2);
    check("rst_busy", busy, 0);
    check("rst_ptw_req", ptw_req, 0);
    check("rst_ptw_va", ptw_va, 0);
    check("rst_valid", {i_valid, d_valid, i_fault, d_fault}, 0);
    check("rst_pa", {i_pa, d_pa}, 0);
    check("rst_terr", timeout_err, 0);
    rst = 1'b0;
    cycles(2);

    // Table: single requests and ties, round-robin order and PA values
    for (int v = 0; v < 5; v++) begin
      s_req = n_req; s_i = n_i; s_d = n_d;
      pulse(vt[v].fi, vt[v].iva, 1'b0, vt[v].fd, vt[v].dva, 1'b0);
      cycles(40);
      check($sformatf("v%0d_busy", v), busy, 0);
      check($sformatf("v%0d_n_i", v), n_i - s_i, vt[v].fi);
      check($sformatf("v%0d_n_d", v), n_d - s_d, vt[v].fd);
      check($sformatf("v%0d_n_req", v), n_req - s_req, 32'(vt[v].fi) + 32'(vt[v].fd));
      if (vt[v].fi) begin
        check($sformatf("v%0d_i_pa", v), got_i_pa, vt[v].ipa);
        check($sformatf("v%0d_i_fault", v), got_i_fault, 0);
        prev_ipa = vt[v].ipa;
      end else begin
        check($sformatf("v%0d_i_pa_held", v), i_pa, prev_ipa);
      end
      if (vt[v].fd) begin
        check($sformatf("v%0d_d_pa", v), got_d_pa, vt[v].dpa);
        check($sformatf("v%0d_d_fault", v), got_d_fault, 0);
        prev_dpa = vt[v].dpa;
      end else begin
        check($sformatf("v%0d_d_pa_held", v), d_pa, prev_dpa);
      end
      if (vt[v].fi && vt[v].fd)
        check($sformatf("v%0d_order", v), d_cyc < i_cyc, vt[v].d_first);
      if (vt[v].fi ^ vt[v].fd) begin
        check($sformatf("v%0d_req_lat", v), last_req_cyc, req_cyc + 1);
        check($sformatf("v%0d_ptw_va", v), last_req_va, vt[v].fi ? vt[v].iva : vt[v].dva);
        check($sformatf("v%0d_resp_lat", v), vt[v].fi ? i_cyc : d_cyc, pv_cyc + 1);
      end
    end

    // DTLB request while ITLB walk is waiting
    s_req = n_req; s_i = n_i; s_d = n_d;
    pulse(1'b1, 32'h0000_3000, 1'b0, 1'b0, '0, 1'b0);
    cycles(3);
    check("q_busy_wait", busy, 1);
    pulse(1'b0, '0, 1'b0, 1'b1, 32'h0000_4000, 1'b0);
    cycles(40);
    check("q_n_req", n_req - s_req, 2);
    check("q_n_i", n_i - s_i, 1);
    check("q_n_d", n_d - s_d, 1);
    check("q_i_pa", got_i_pa, 20'h03004);
    check("q_d_pa", got_d_pa, 20'h04004);
    check("q_d_issue", last_req_cyc, i_cyc + 2);
    check("q_d_va", last_req_va, 32'h0000_4000);

    // Flush of the owner during WAIT
    s_req = n_req; s_i = n_i;
    pulse(1'b1, 32'h0000_6000, 1'b0, 1'b0, '0, 1'b0);
    cycles(3);
    pulse(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    cycles(30);
    check("f_n_i", n_i - s_i, 0);
    check("f_n_req", n_req - s_req, 1);
    check("f_idle_after_resp", last_busy_cyc, pv_cyc + 1);
    check("f_busy", busy, 0);
    // Request together with flush is discarded
    s_req = n_req;
    pulse(1'b1, 32'h0000_6100, 1'b1, 1'b0, '0, 1'b0);
    cycles(5);
    check("f_reqflush_req", n_req - s_req, 0);
    check("f_reqflush_busy", busy, 0);
    s_i = n_i;
    pulse(1'b1, 32'h0000_7000, 1'b0, 1'b0, '0, 1'b0);
    cycles(30);
    check("f_after_n_i", n_i - s_i, 1);
    check("f_after_pa", got_i_pa, 20'h07004);

    // Watchdog timeout, then a late ptw response
    stub_en = 1'b0;
    s_i = n_i; s_d = n_d;
    pulse(1'b1, 32'h0000_2000, 1'b0, 1'b0, '0, 1'b0);
    cycles(40);
    check("t_n_i", n_i - s_i, 1);
    check("t_fault", got_i_fault, 1);
    check("t_pa", got_i_pa, 0);
    check("t_terr", timeout_err, 1);
    check("t_lat", i_cyc, last_req_cyc + 17);
    @(negedge clk);
    force_valid = 1'b1; force_pa = 20'h12345;
    @(negedge clk);
    force_valid = 1'b0;
    cycles(3);
    check("t_late_n", (n_i - s_i) + (n_d - s_d), 1);
    check("t_late_pa", i_pa, 0);
    check("t_late_busy", busy, 0);
    check("t_terr_sticky", timeout_err, 1);
    stub_en = 1'b1;

    // Asynchronous reset mid-walk, stale response afterwards
    s_i = n_i; s_d = n_d;
    pulse(1'b1, 32'h0000_9000, 1'b0, 1'b0, '0, 1'b0);
    cycles(3);
    #2 rst = 1'b1;
    #1;
    check("r_busy", busy, 0);
    check("r_ptw", {ptw_req, ptw_va}, 0);
    check("r_out", {i_valid, i_fault, i_pa, d_pa}, 0);
    check("r_terr", timeout_err, 0);
    @(negedge clk);
    rst = 1'b0;
    cycles(20);
    check("r_stale_n", (n_i - s_i) + (n_d - s_d), 0);
    check("r_stale_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
